// File: rtl/mssd_pkg.sv
// Shared definitions for the MSSD serial message link (scheduler and deserializer).
package mssd_pkg;

  localparam int PORT_W = 2;
  localparam int LEN_W  = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic IDLE_BIT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    PORT  = 3'd2,
    LEN   = 3'd3,
    DATA  = 3'd4,
    GUARD = 3'd5
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] winner,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  int k;

  // Scan from ptr upward; the first hit wins.
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = 1'b0;
    k      = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr) + i) % NREQ;
      if (!valid && req[k]) begin
        valid     = 1'b1;
        winner[k] = 1'b1;
        idx       = IW'(k);
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/mssd_tx_scheduler.sv
// Round-robin framer sharing one serial link: start, port, length, then data bytes MSB first.
module mssd_tx_scheduler #(
  parameter  int PORT_W = mssd_pkg::PORT_W,
  parameter  int LEN_W  = mssd_pkg::LEN_W,
  parameter  int GUARD  = 1,
  localparam int NREQ   = 2**PORT_W
) (
  input  logic                  Clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LEN_W-1:0] len,
  input  logic [NREQ*8-1:0]     wr_data,
  output logic                  serOut,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       byte_rd,
  output logic [NREQ-1:0]       done,
  output logic                  busy
);
  import mssd_pkg::*;

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

  state_t            state_r, state_s;
  logic [2:0]        bit_cnt_r, bit_cnt_s;
  logic [LEN_W-1:0]  byte_cnt_r, byte_cnt_s;
  logic [LEN_W-1:0]  len_r, len_s;
  logic [PORT_W-1:0] idx_r, idx_s, rr_ptr_r, rr_ptr_s;
  logic [GW-1:0]     guard_cnt_r, guard_cnt_s;
  logic [7:0]        shift_r, shift_s;
  logic [NREQ-1:0]   gnt_r, gnt_s, byte_rd_r, byte_rd_s, done_r, done_s;
  logic              ser_r, ser_s, busy_r, busy_s;

  logic [NREQ-1:0]   win_onehot_s;
  logic [PORT_W-1:0] win_idx_s;
  logic              win_valid_s;
  logic [7:0]        sel_data_s;
  logic [LEN_W-1:0]  win_len_s;
  logic [PORT_W-1:0] port_shift_s;
  logic [LEN_W-1:0]  len_shift_s;
  logic              last_bit_s, final_s;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .ptr    (rr_ptr_r),
    .winner (win_onehot_s),
    .idx    (win_idx_s),
    .valid  (win_valid_s)
  );

  assign sel_data_s = wr_data[idx_r*8 +: 8];
  assign win_len_s  = len[win_idx_s*LEN_W +: LEN_W];

  // Frame sequencing; outputs are precomputed from the next state so they leave flops.
  always_comb begin
    state_s     = state_r;
    bit_cnt_s   = bit_cnt_r;
    byte_cnt_s  = byte_cnt_r;
    len_s       = len_r;
    idx_s       = idx_r;
    rr_ptr_s    = rr_ptr_r;
    guard_cnt_s = guard_cnt_r;
    shift_s     = shift_r;
    gnt_s       = gnt_r;
    case (state_r)
      mssd_pkg::IDLE: begin
        if (win_valid_s) begin
          state_s  = mssd_pkg::START;
          idx_s    = win_idx_s;
          gnt_s    = win_onehot_s;
          len_s    = win_len_s;
          rr_ptr_s = win_idx_s + PORT_W'(1);
        end else begin
          state_s = mssd_pkg::IDLE;
        end
      end
      mssd_pkg::START: begin
        state_s   = mssd_pkg::PORT;
        bit_cnt_s = 3'(PORT_W - 1);
      end
      mssd_pkg::PORT: begin
        if (bit_cnt_r == 3'd0) begin
          state_s   = mssd_pkg::LEN;
          bit_cnt_s = 3'(LEN_W - 1);
        end else begin
          bit_cnt_s = bit_cnt_r - 3'd1;
        end
      end
      mssd_pkg::LEN: begin
        if (bit_cnt_r != 3'd0) begin
          bit_cnt_s = bit_cnt_r - 3'd1;
        end else if (len_r == {LEN_W{1'b0}}) begin
          state_s     = mssd_pkg::GUARD;
          gnt_s       = '0;
          guard_cnt_s = GUARD_LAST;
        end else begin
          state_s    = mssd_pkg::DATA;
          bit_cnt_s  = 3'd7;
          shift_s    = sel_data_s;
          byte_cnt_s = len_r - LEN_W'(1);
        end
      end
      mssd_pkg::DATA: begin
        if (bit_cnt_r != 3'd0) begin
          bit_cnt_s = bit_cnt_r - 3'd1;
          shift_s   = {shift_r[6:0], 1'b0};
        end else if (byte_cnt_r == {LEN_W{1'b0}}) begin
          state_s     = mssd_pkg::GUARD;
          gnt_s       = '0;
          guard_cnt_s = GUARD_LAST;
        end else begin
          bit_cnt_s  = 3'd7;
          shift_s    = sel_data_s;
          byte_cnt_s = byte_cnt_r - LEN_W'(1);
        end
      end
      mssd_pkg::GUARD: begin
        if (guard_cnt_r == {GW{1'b0}}) begin
          state_s = mssd_pkg::IDLE;
        end else begin
          guard_cnt_s = guard_cnt_r - GW'(1);
        end
      end
      default: begin
        state_s = mssd_pkg::IDLE;
        gnt_s   = '0;
      end
    endcase

    port_shift_s = idx_s >> bit_cnt_s;
    len_shift_s  = len_s >> bit_cnt_s;
    case (state_s)
      mssd_pkg::START: ser_s = START_BIT;
      mssd_pkg::PORT:  ser_s = port_shift_s[0];
      mssd_pkg::LEN:   ser_s = len_shift_s[0];
      mssd_pkg::DATA:  ser_s = shift_s[7];
      default:         ser_s = IDLE_BIT;
    endcase

    // A byte is fetched on the last bit of LEN or of any byte, unless that bit ends the frame.
    last_bit_s = ((state_s == mssd_pkg::LEN) || (state_s == mssd_pkg::DATA)) && (bit_cnt_s == 3'd0);
    final_s    = last_bit_s &&
                 (((state_s == mssd_pkg::LEN)  && (len_s == {LEN_W{1'b0}})) ||
                  ((state_s == mssd_pkg::DATA) && (byte_cnt_s == {LEN_W{1'b0}})));
    done_s    = gnt_s & {NREQ{final_s}};
    byte_rd_s = gnt_s & {NREQ{last_bit_s && !final_s}};
    busy_s    = (state_s != mssd_pkg::IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_r     <= mssd_pkg::IDLE;
      bit_cnt_r   <= 3'd0;
      byte_cnt_r  <= {LEN_W{1'b0}};
      len_r       <= {LEN_W{1'b0}};
      idx_r       <= {PORT_W{1'b0}};
      rr_ptr_r    <= {PORT_W{1'b0}};
      guard_cnt_r <= {GW{1'b0}};
      shift_r     <= 8'h00;
      gnt_r       <= {NREQ{1'b0}};
      byte_rd_r   <= {NREQ{1'b0}};
      done_r      <= {NREQ{1'b0}};
      ser_r       <= IDLE_BIT;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      bit_cnt_r   <= bit_cnt_s;
      byte_cnt_r  <= byte_cnt_s;
      len_r       <= len_s;
      idx_r       <= idx_s;
      rr_ptr_r    <= rr_ptr_s;
      guard_cnt_r <= guard_cnt_s;
      shift_r     <= shift_s;
      gnt_r       <= gnt_s;
      byte_rd_r   <= byte_rd_s;
      done_r      <= done_s;
      ser_r       <= ser_s;
      busy_r      <= busy_s;
    end
  end

  assign serOut  = ser_r;
  assign gnt     = gnt_r;
  assign byte_rd = byte_rd_r;
  assign done    = done_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_mssd_tx_scheduler.sv
// Directed scoreboard bench for mssd_tx_scheduler: expected frame bits queued, popped per cycle.
module tb_mssd_tx_scheduler;

  logic        Clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] len = 16'h0000;
  logic [31:0] wr_data = 32'h0;
  logic        serOut;
  logic [3:0]  gnt, byte_rd, done;
  logic        busy;

  int checks = 0;
  int failures = 0;
  bit exp_q[$];
  logic [7:0] mem [4][16];
  int ptr [4];
  int lat;

  mssd_tx_scheduler #(.PORT_W(2), .LEN_W(4), .GUARD(1)) dut (
    .Clk(Clk), .reset(reset), .req(req), .len(len), .wr_data(wr_data),
    .serOut(serOut), .gnt(gnt), .byte_rd(byte_rd), .done(done), .busy(busy)
  );

  always #5 Clk = ~Clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_wd();
    for (int i = 0; i < 4; i++) wr_data[i*8 +: 8] = mem[i][ptr[i] & 15];
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ser"}, 32'(serOut), 32'd1);
    chk({tag, "_gnt"}, 32'(gnt), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic push_frame(input int p, input int l);
    logic [7:0] bv;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int b = 1; b >= 0; b--) exp_q.push_back(p[b]);
    for (int b = 3; b >= 0; b--) exp_q.push_back(l[b]);
    for (int j = 0; j < l; j++) begin
      bv = mem[p][j];
      for (int b = 7; b >= 0; b--) exp_q.push_back(bv[b]);
    end
  endtask

  // Follows one frame from its start bit through the guard cycle.
  task automatic run_frame(input int p, input int l, input logic [3:0] req_after,
                           input logic [15:0] len_after, output int latency);
    int bitpos, rd_cnt, exp_rd;
    bit adv, e;
    logic [3:0] g;
    push_frame(p, l);
    g = 4'b0001 << p;
    ptr[p] = 0;
    drive_wd();
    latency = 0;
    @(negedge Clk);
    while (serOut !== 1'b0 && latency < 40) begin
      latency++;
      @(negedge Clk);
    end
    if (latency >= 40) begin
      chk("start_timeout", 32'(latency), 32'd0);
      return;
    end
    bitpos = 0; rd_cnt = 0; adv = 1'b0;
    while (exp_q.size() > 0) begin
      if (adv) begin ptr[p]++; drive_wd(); adv = 1'b0; end
      e = exp_q.pop_front();
      exp_rd = 0;
      if (l > 0 && bitpos == 6) exp_rd = 1;
      if (bitpos >= 7 && ((bitpos - 7) % 8) == 7 && ((bitpos - 7) / 8) < l - 1) exp_rd = 1;
      chk("ser", 32'(serOut), 32'(e));
      chk("gnt", 32'(gnt), 32'(g));
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), (exp_q.size() == 0) ? 32'(g) : 32'd0);
      chk("byte_rd", 32'(byte_rd), (exp_rd != 0) ? 32'(g) : 32'd0);
      if (byte_rd[p]) begin rd_cnt++; adv = 1'b1; end
      if ((l > 0 && bitpos == 7) || (l == 0 && bitpos == 0)) begin
        req = req_after;
        len = len_after;
      end
      bitpos++;
      @(negedge Clk);
    end
    chk("guard_ser", 32'(serOut), 32'd1);
    chk("guard_gnt", 32'(gnt), 32'd0);
    chk("guard_busy", 32'(busy), 32'd1);
    chk("guard_pulses", 32'({done, byte_rd}), 32'd0);
    chk("byte_rd_count", 32'(rd_cnt), 32'(l));
  endtask

  task automatic do_reset();
    @(negedge Clk);
    reset = 1'b0;
    req = 4'b0000;
    repeat (2) @(negedge Clk);
    check_quiet("reset");
    chk("reset_pulses", 32'({done, byte_rd}), 32'd0);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      ptr[i] = 0;
      for (int j = 0; j < 16; j++) mem[i][j] = 8'((i * 37 + j * 11 + 5) & 255);
    end
    drive_wd();

    // 1: reset state and idle line
    do_reset();
    repeat (20) begin
      @(negedge Clk);
      check_quiet("idle");
    end

    // 2: single frame from requester 2, two bytes
    mem[2][0] = 8'hA5; mem[2][1] = 8'h3C;
    len = 16'h0200;
    req = 4'b0100;
    run_frame(2, 2, 4'b0000, len, lat);
    chk("latency", 32'(lat), 32'd0);

    // 4: zero-length frame from requester 1
    len = 16'h0000;
    req = 4'b0010;
    run_frame(1, 0, 4'b0000, len, lat);
    @(negedge Clk);
    check_quiet("after_len0");

    // 3: all requesting, round-robin from a fresh pointer
    do_reset();
    for (int i = 0; i < 4; i++) mem[i][0] = 8'(8'h50 + i);
    len = 16'h1111;
    req = 4'b1111;
    run_frame(0, 1, 4'b1111, len, lat);
    run_frame(1, 1, 4'b1111, len, lat);
    chk("rr_gap", 32'(lat), 32'd1);
    run_frame(2, 1, 4'b1111, len, lat);
    run_frame(3, 1, 4'b1111, len, lat);
    run_frame(0, 1, 4'b0000, len, lat);

    // 5: reset in the middle of a long frame
    do_reset();
    for (int j = 0; j < 16; j++) mem[3][j] = 8'(8'hC0 ^ (j * 7));
    len = 16'hF000;
    ptr[3] = 0;
    drive_wd();
    req = 4'b1000;
    lat = 0;
    @(negedge Clk);
    while (serOut !== 1'b0 && lat < 40) begin lat++; @(negedge Clk); end
    chk("abort_start", 32'(lat), 32'd0);
    repeat (12) @(negedge Clk);
    chk("abort_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    check_quiet("abort");
    chk("abort_pulses", 32'({done, byte_rd}), 32'd0);
    mem[0][0] = 8'h96;
    len = 16'hF001;
    req = 4'b1001;
    @(negedge Clk);
    reset = 1'b1;
    run_frame(0, 1, 4'b1000, len, lat);
    run_frame(3, 15, 4'b0000, len, lat);

    // 6: requester 0 drops req and changes len mid-frame
    mem[0][0] = 8'h12; mem[0][1] = 8'h34; mem[0][2] = 8'h56;
    mem[2][0] = 8'hE7; mem[2][1] = 8'h01;
    len = 16'h0203;
    req = 4'b0101;
    run_frame(0, 3, 4'b0100, 16'h0205, lat);
    run_frame(2, 2, 4'b0000, 16'h0205, lat);
    @(negedge Clk);
    check_quiet("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
